// File: rtl/alu_pkg.sv
// Shared definitions for the ALU family: datapath width, sequencer states
// and the five-flag result record used by the adder, subtractor and flag register.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic sign;
        logic zero;
        logic carry;
        logic parity;
        logic overflow;
    } alu_flags_t;

    // Signed overflow of a - b, judged from the operand and result sign bits.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic d_msb);
        return (a_msb & ~b_msb & ~d_msb) | (~a_msb & b_msb & d_msb);
    endfunction

endpackage

// File: rtl/fsub1.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module fsub1 (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/sub16_serial_alu.sv
// Bit-serial a - b, LSB first, one bit per clock, with a start/done handshake.
// Result and flags are registered and only change on the edge entering DONE.
module sub16_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             sign,
    output logic             zero,
    output logic             carry,
    output logic             parity,
    output logic             overflow
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    alu_state_e       state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    // Holds the WIDTH-1 bits already produced; the last bit goes straight to out.
    logic [WIDTH-2:0] res_q;
    logic             bw_q;
    logic [CNT_W-1:0] cnt_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] out_q;
    alu_flags_t       flags_q;

    logic             diff_bit;
    logic             bw_d;
    logic [WIDTH-1:0] res_d;
    alu_flags_t       flags_d;

    fsub1 u_fsub1 (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .bin_i  (bw_q),
        .d_o    (diff_bit),
        .bout_o (bw_d)
    );

    // Candidate full result and flags as they would stand after this cycle's bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        flags_d          = '0;
        res_d            = {diff_bit, res_q};
        flags_d.sign     = res_d[WIDTH-1];
        flags_d.zero     = ~|res_d;
        flags_d.carry    = bw_d;
        flags_d.parity   = ~^res_d;
        flags_d.overflow = sub_overflow(a_msb_q, b_msb_q, res_d[WIDTH-1]);
    end

    // Sequencer and serial datapath: accept, shift one bit per cycle, load result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            bw_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                        bw_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    res_q  <= res_d[WIDTH-1:1];
                    bw_q   <= bw_d;
                    if (cnt_q == CNT_LAST) begin
                        out_q   <= res_d;
                        flags_q <= flags_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign out      = out_q;
    assign sign     = flags_q.sign;
    assign zero     = flags_q.zero;
    assign carry    = flags_q.carry;
    assign parity   = flags_q.parity;
    assign overflow = flags_q.overflow;

endmodule
